// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL dynamic-reconfiguration sequencer: loads ratio/duty values, holds the PLL in reset,
// qualifies a stable lock, and issues fine phase-step pulses on request.
module pll_dyn_cfg_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned PS_GAP       = 4,
    parameter logic [9:0]  INIT_IDIV    = 10'd3,
    parameter logic [9:0]  INIT_FDIV    = 10'd49,
    parameter logic [9:0]  INIT_ODIV0   = 10'd11,
    parameter logic [9:0]  INIT_ODIV1   = 10'd33,
    parameter logic [9:0]  INIT_DUTY0   = 10'd11,
    parameter logic [9:0]  INIT_DUTY1   = 10'd33
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       cfg_req,
    input  logic [9:0] cfg_idiv,
    input  logic [9:0] cfg_fdiv,
    input  logic [9:0] cfg_odiv0,
    input  logic [9:0] cfg_odiv1,
    input  logic [9:0] cfg_duty0,
    input  logic [9:0] cfg_duty1,
    output logic       cfg_ack,
    input  logic       ps_req,
    input  logic [2:0] ps_sel_in,
    input  logic       ps_dir_in,
    input  logic [7:0] ps_steps,
    output logic       ps_ack,
    input  logic       pll_lock,
    output logic [9:0] dyn_idiv,
    output logic [9:0] dyn_fdiv,
    output logic [9:0] dyn_odiv0,
    output logic [9:0] dyn_odiv1,
    output logic [9:0] dyn_duty0,
    output logic [9:0] dyn_duty1,
    output logic       pll_rst_o,
    output logic [2:0] phase_sel,
    output logic       phase_dir,
    output logic       phase_step_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       locked
);

    localparam int RC_W  = $clog2(RST_CYCLES);
    localparam int LS_W  = $clog2(LOCK_STABLE + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(PS_GAP + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD_RST,
        ST_LOCK_WAIT,
        ST_PS_STEP,
        ST_PS_GAP
    } state_t;

    state_t state_q, state_d;

    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [LS_W-1:0]  stab_q, stab_d, stab_inc;
    logic [TO_W-1:0]  to_q, to_d, to_inc;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [9:0] idiv_q, idiv_d, fdiv_q, fdiv_d;
    logic [9:0] odiv0_q, odiv0_d, odiv1_q, odiv1_d;
    logic [9:0] duty0_q, duty0_d, duty1_q, duty1_d;

    logic       pll_rst_q, pll_rst_d;
    logic [2:0] sel_q, sel_d;
    logic       dir_q, dir_d;
    logic       step_n_q, step_n_d;
    logic       cfg_ack_q, cfg_ack_d;
    logic       ps_ack_q, ps_ack_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       locked_q, locked_d;

    logic lock_meta_q, lock_s_q;

    // Duty is counted in half-VCO cycles, so the legal range is 1 .. 2*odiv-1.
    function automatic logic cfg_valid(
        input logic [9:0] idiv,
        input logic [9:0] fdiv,
        input logic [9:0] odiv0,
        input logic [9:0] odiv1,
        input logic [9:0] duty0,
        input logic [9:0] duty1
    );
        logic [10:0] lim0;
        logic [10:0] lim1;
        lim0 = {odiv0, 1'b0} - 11'd1;
        lim1 = {odiv1, 1'b0} - 11'd1;
        return (idiv != 10'd0) && (fdiv != 10'd0) &&
               (odiv0 != 10'd0) && (odiv1 != 10'd0) &&
               (duty0 != 10'd0) && ({1'b0, duty0} <= lim0) &&
               (duty1 != 10'd0) && ({1'b0, duty1} <= lim1);
    endfunction

    always_ff @(posedge clkin1) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        stab_d     = stab_q;
        to_d       = to_q;
        step_cnt_d = step_cnt_q;
        gap_d      = gap_q;
        idiv_d     = idiv_q;
        fdiv_d     = fdiv_q;
        odiv0_d    = odiv0_q;
        odiv1_d    = odiv1_q;
        duty0_d    = duty0_q;
        duty1_d    = duty1_q;
        pll_rst_d  = pll_rst_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        step_n_d   = 1'b1;
        cfg_ack_d  = 1'b0;
        ps_ack_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        locked_d   = locked_q;
        stab_inc   = lock_s_q ? stab_q + LS_W'(1) : '0;
        to_inc     = to_q + TO_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (locked_q && !lock_s_q) begin
                    locked_d = 1'b0;
                end
                if (cfg_req) begin
                    if (cfg_valid(cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_odiv1, cfg_duty0, cfg_duty1)) begin
                        cfg_ack_d = 1'b1;
                        idiv_d    = cfg_idiv;
                        fdiv_d    = cfg_fdiv;
                        odiv0_d   = cfg_odiv0;
                        odiv1_d   = cfg_odiv1;
                        duty0_d   = cfg_duty0;
                        duty1_d   = cfg_duty1;
                        pll_rst_d = 1'b1;
                        locked_d  = 1'b0;
                        rst_cnt_d = '0;
                        state_d   = ST_HOLD_RST;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ps_req) begin
                    if (!locked_q) begin
                        err_d = 1'b1;
                    end else begin
                        ps_ack_d   = 1'b1;
                        sel_d      = ps_sel_in;
                        dir_d      = ps_dir_in;
                        step_cnt_d = ps_steps;
                        state_d    = ST_PS_STEP;
                    end
                end
            end
            ST_HOLD_RST: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    pll_rst_d = 1'b0;
                    stab_d    = '0;
                    to_d      = '0;
                    state_d   = ST_LOCK_WAIT;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_LOCK_WAIT: begin
                stab_d = stab_inc;
                to_d   = to_inc;
                // A lock that qualifies on the timeout cycle still counts as success.
                if (stab_inc == LS_W'(LOCK_STABLE)) begin
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (to_inc == TO_W'(LOCK_TIMEOUT)) begin
                    locked_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_PS_STEP: begin
                // An exhausted count here (including ps_steps=0) completes the sequence.
                if (step_cnt_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    step_n_d   = 1'b0;
                    step_cnt_d = step_cnt_q - 8'd1;
                    gap_d      = '0;
                    state_d    = ST_PS_GAP;
                end
            end
            ST_PS_GAP: begin
                if (gap_q == GAP_W'(PS_GAP - 1)) begin
                    state_d = ST_PS_STEP;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset restarts a full PLL reset-and-lock sequence using the INIT values.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q    <= ST_HOLD_RST;
            rst_cnt_q  <= '0;
            stab_q     <= '0;
            to_q       <= '0;
            step_cnt_q <= 8'd0;
            gap_q      <= '0;
            idiv_q     <= INIT_IDIV;
            fdiv_q     <= INIT_FDIV;
            odiv0_q    <= INIT_ODIV0;
            odiv1_q    <= INIT_ODIV1;
            duty0_q    <= INIT_DUTY0;
            duty1_q    <= INIT_DUTY1;
            pll_rst_q  <= 1'b1;
            sel_q      <= 3'd0;
            dir_q      <= 1'b0;
            step_n_q   <= 1'b1;
            cfg_ack_q  <= 1'b0;
            ps_ack_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            stab_q     <= stab_d;
            to_q       <= to_d;
            step_cnt_q <= step_cnt_d;
            gap_q      <= gap_d;
            idiv_q     <= idiv_d;
            fdiv_q     <= fdiv_d;
            odiv0_q    <= odiv0_d;
            odiv1_q    <= odiv1_d;
            duty0_q    <= duty0_d;
            duty1_q    <= duty1_d;
            pll_rst_q  <= pll_rst_d;
            sel_q      <= sel_d;
            dir_q      <= dir_d;
            step_n_q   <= step_n_d;
            cfg_ack_q  <= cfg_ack_d;
            ps_ack_q   <= ps_ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    assign dyn_idiv     = idiv_q;
    assign dyn_fdiv     = fdiv_q;
    assign dyn_odiv0    = odiv0_q;
    assign dyn_odiv1    = odiv1_q;
    assign dyn_duty0    = duty0_q;
    assign dyn_duty1    = duty1_q;
    assign pll_rst_o    = pll_rst_q;
    assign phase_sel    = sel_q;
    assign phase_dir    = dir_q;
    assign phase_step_n = step_n_q;
    assign cfg_ack      = cfg_ack_q;
    assign ps_ack       = ps_ack_q;
    assign done         = done_q;
    assign err          = err_q;
    assign locked       = locked_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Self-checking bench for pll_dyn_cfg_ctrl: randomized requests against a timing/value
// reference model derived from the sequencer's documented behaviour.
module tb_pll_dyn_cfg_ctrl;

    localparam int R  = 16;
    localparam int LS = 64;
    localparam int LT = 200;
    localparam int PG = 4;
    // Index order: 0 idiv, 1 fdiv, 2 odiv0, 3 odiv1, 4 duty0, 5 duty1
    localparam logic [5:0][9:0] INIT_PK = {10'd33, 10'd11, 10'd33, 10'd11, 10'd49, 10'd3};

    logic       clkin1 = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_req = 1'b0;
    logic [9:0] cfg_idiv = '0, cfg_fdiv = '0, cfg_odiv0 = '0, cfg_odiv1 = '0;
    logic [9:0] cfg_duty0 = '0, cfg_duty1 = '0;
    logic       cfg_ack;
    logic       ps_req = 1'b0;
    logic [2:0] ps_sel_in = '0;
    logic       ps_dir_in = 1'b0;
    logic [7:0] ps_steps = '0;
    logic       ps_ack;
    logic       pll_lock;
    logic       lock_en = 1'b1;
    logic [9:0] dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1;
    logic       pll_rst_o;
    logic [2:0] phase_sel;
    logic       phase_dir, phase_step_n, busy, done, err, locked;

    logic [5:0][9:0] dyn_obs;
    logic [5:0][9:0] exp_dyn;
    bit              exp_locked;
    int              n_vec = 0;
    int              n_err = 0;

    // Behavioural PLL: lock is lost while held in reset and returns once released.
    assign pll_lock = lock_en & ~pll_rst_o;
    assign dyn_obs  = {dyn_duty1, dyn_duty0, dyn_odiv1, dyn_odiv0, dyn_fdiv, dyn_idiv};

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES  (R),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(LT),
        .PS_GAP      (PG)
    ) dut (
        .clkin1      (clkin1),
        .rst         (rst),
        .cfg_req     (cfg_req),
        .cfg_idiv    (cfg_idiv),
        .cfg_fdiv    (cfg_fdiv),
        .cfg_odiv0   (cfg_odiv0),
        .cfg_odiv1   (cfg_odiv1),
        .cfg_duty0   (cfg_duty0),
        .cfg_duty1   (cfg_duty1),
        .cfg_ack     (cfg_ack),
        .ps_req      (ps_req),
        .ps_sel_in   (ps_sel_in),
        .ps_dir_in   (ps_dir_in),
        .ps_steps    (ps_steps),
        .ps_ack      (ps_ack),
        .pll_lock    (pll_lock),
        .dyn_idiv    (dyn_idiv),
        .dyn_fdiv    (dyn_fdiv),
        .dyn_odiv0   (dyn_odiv0),
        .dyn_odiv1   (dyn_odiv1),
        .dyn_duty0   (dyn_duty0),
        .dyn_duty1   (dyn_duty1),
        .pll_rst_o   (pll_rst_o),
        .phase_sel   (phase_sel),
        .phase_dir   (phase_dir),
        .phase_step_n(phase_step_n),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .locked      (locked)
    );

    always #10 clkin1 = ~clkin1;

    initial begin
        #1600000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clkin1);
        #1;
    endtask

    task automatic drive_cfg(input logic [5:0][9:0] v);
        cfg_idiv  = v[0];
        cfg_fdiv  = v[1];
        cfg_odiv0 = v[2];
        cfg_odiv1 = v[3];
        cfg_duty0 = v[4];
        cfg_duty1 = v[5];
    endtask

    function automatic bit ref_valid(input logic [5:0][9:0] v);
        int d0, d1, o0, o1;
        o0 = int'(v[2]);
        o1 = int'(v[3]);
        d0 = int'(v[4]);
        d1 = int'(v[5]);
        return (v[0] != 0) && (v[1] != 0) && (o0 >= 1) && (o1 >= 1) &&
               (d0 >= 1) && (d0 <= 2 * o0 - 1) && (d1 >= 1) && (d1 <= 2 * o1 - 1);
    endfunction

    function automatic logic [5:0][9:0] rand_valid();
        logic [5:0][9:0] v;
        int lim;
        v[0] = 10'(1 + $urandom % 1023);
        v[1] = 10'(1 + $urandom % 1023);
        v[2] = 10'(1 + $urandom % 1023);
        v[3] = 10'(1 + $urandom % 1023);
        lim  = 2 * int'(v[2]) - 1;
        if (lim > 1023) lim = 1023;
        v[4] = 10'(1 + $urandom % lim);
        lim  = 2 * int'(v[3]) - 1;
        if (lim > 1023) lim = 1023;
        v[5] = 10'(1 + $urandom % lim);
        return v;
    endfunction

    task automatic test_reset();
        int n, m;
        bit seen_err;
        rst = 1'b1;
        cfg_req = 1'($urandom);
        ps_req = 1'($urandom);
        lock_en = 1'b1;
        drive_cfg(rand_valid());
        repeat (3) tick();
        n_vec++;
        if (dyn_obs !== INIT_PK) begin
            n_err++;
            $display("FAIL reset_dyn got %h want %h", dyn_obs, INIT_PK);
        end
        n_vec++;
        if ({pll_rst_o, busy, phase_step_n, phase_sel, phase_dir, cfg_ack, ps_ack, done, err, locked}
            !== {1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 5'b0}) begin
            n_err++;
            $display("FAIL reset_ctrl got rst=%b busy=%b stepn=%b sel=%0d dir=%b ack=%b/%b done=%b err=%b lk=%b want 1 1 1 0 0 0/0 0 0 0",
                     pll_rst_o, busy, phase_step_n, phase_sel, phase_dir, cfg_ack, ps_ack, done, err, locked);
        end
        cfg_req = 1'b0;
        ps_req = 1'b0;
        rst = 1'b0;
        exp_dyn = INIT_PK;
        n = 0;
        while (pll_rst_o === 1'b1 && n < 4 * R) begin
            n++;
            tick();
        end
        n_vec++;
        if (n != R) begin
            n_err++;
            $display("FAIL reset_hold pll_rst_o high %0d cycles, want %0d", n, R);
        end
        m = 0;
        seen_err = 0;
        while (done !== 1'b1 && m < 4 * LS) begin
            if (err === 1'b1) seen_err = 1;
            m++;
            tick();
        end
        n_vec++;
        if (m != LS + 2 || seen_err) begin
            n_err++;
            $display("FAIL reset_lock done after %0d cycles (err seen %0d), want %0d", m, seen_err, LS + 2);
        end
        n_vec++;
        if (locked !== 1'b1 || busy !== 1'b0 || dyn_obs !== exp_dyn) begin
            n_err++;
            $display("FAIL reset_final locked=%b busy=%b dyn=%h want 1 0 %h", locked, busy, dyn_obs, exp_dyn);
        end
        exp_locked = 1;
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done_pulse done=%b want 0", done);
        end
    endtask

    task automatic test_cfg(input logic [5:0][9:0] v, input bit also_ps, input bit lock_ok);
        int n, m;
        bit stray;
        drive_cfg(v);
        cfg_req = 1'b1;
        ps_req = also_ps;
        ps_steps = 8'd2;
        ps_sel_in = 3'($urandom);
        tick();
        cfg_req = 1'b0;
        ps_req = 1'b0;
        exp_dyn = v;
        n_vec++;
        if (cfg_ack !== 1'b1 || ps_ack !== 1'b0 || dyn_obs !== exp_dyn || locked !== 1'b0 ||
            pll_rst_o !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_accept ack=%b psack=%b dyn=%h lk=%b rst=%b busy=%b want 1 0 %h 0 1 1",
                     cfg_ack, ps_ack, dyn_obs, locked, pll_rst_o, busy, exp_dyn);
        end
        n = 0;
        stray = 0;
        while (pll_rst_o === 1'b1 && n < 4 * R) begin
            if (n > 0 && (cfg_ack !== 1'b0 || ps_ack !== 1'b0 || err !== 1'b0 || done !== 1'b0)) stray = 1;
            if (phase_step_n !== 1'b1) stray = 1;
            cfg_req = 1'($urandom);
            ps_req = 1'($urandom);
            drive_cfg(rand_valid());
            n++;
            tick();
        end
        cfg_req = 1'b0;
        ps_req = 1'b0;
        n_vec++;
        if (n != R || stray) begin
            n_err++;
            $display("FAIL cfg_hold pll_rst_o high %0d cycles (stray %0d), want %0d (stray 0)", n, stray, R);
        end
        m = 0;
        while (done !== 1'b1 && err !== 1'b1 && m < LT + LS + 50) begin
            if (cfg_ack !== 1'b0 || ps_ack !== 1'b0 || phase_step_n !== 1'b1) stray = 1;
            m++;
            tick();
        end
        n_vec++;
        if (lock_ok && (m != LS + 2 || done !== 1'b1 || stray)) begin
            n_err++;
            $display("FAIL cfg_relock done=%b after %0d cycles (stray %0d), want done after %0d", done, m, stray, LS + 2);
        end else if (!lock_ok && (m != LT || err !== 1'b1 || stray)) begin
            n_err++;
            $display("FAIL cfg_timeout err=%b after %0d cycles (stray %0d), want err after %0d", err, m, stray, LT);
        end
        n_vec++;
        if (locked !== lock_ok || busy !== 1'b0 || dyn_obs !== exp_dyn || done === err) begin
            n_err++;
            $display("FAIL cfg_final locked=%b busy=%b done=%b err=%b dyn=%h want %b 0 %b %b %h",
                     locked, busy, done, err, dyn_obs, lock_ok, lock_ok, !lock_ok, exp_dyn);
        end
        exp_locked = lock_ok;
        tick();
    endtask

    task automatic test_cfg_invalid(input int num);
        logic [5:0][9:0] v;
        for (int i = 0; i < num + 2; i++) begin
            v = rand_valid();
            if (i == num) begin
                v = INIT_PK;
                v[2] = 10'd0;
            end else if (i == num + 1) begin
                v = INIT_PK;
                v[4] = 10'd22;
            end else begin
                case ($urandom % 5)
                    0: v[$urandom % 4] = 10'd0;
                    1: v[4] = 10'd0;
                    2: begin
                        v[2] = 10'(1 + $urandom % 500);
                        v[4] = 10'(2 * int'(v[2]) + $urandom % 3);
                    end
                    3: begin
                        v[3] = 10'(1 + $urandom % 500);
                        v[5] = 10'(2 * int'(v[3]) + $urandom % 3);
                    end
                    default: v[5] = 10'd0;
                endcase
            end
            if (ref_valid(v)) continue;
            drive_cfg(v);
            cfg_req = 1'b1;
            ps_req = 1'($urandom);
            tick();
            cfg_req = 1'b0;
            ps_req = 1'b0;
            n_vec++;
            if (err !== 1'b1 || cfg_ack !== 1'b0 || ps_ack !== 1'b0 || busy !== 1'b0 ||
                dyn_obs !== exp_dyn || locked !== exp_locked) begin
                n_err++;
                $display("FAIL cfg_invalid[%0d] err=%b ack=%b psack=%b busy=%b dyn=%h lk=%b want 1 0 0 0 %h %b",
                         i, err, cfg_ack, ps_ack, busy, dyn_obs, locked, exp_dyn, exp_locked);
            end
            tick();
            n_vec++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL cfg_invalid_pulse[%0d] err=%b busy=%b want 0 0", i, err, busy);
            end
        end
    endtask

    task automatic test_phase(input logic [2:0] sel, input logic dir, input int steps);
        int total;
        bit exp_low, exp_done;
        ps_sel_in = sel;
        ps_dir_in = dir;
        ps_steps = 8'(steps);
        ps_req = 1'b1;
        tick();
        n_vec++;
        if (ps_ack !== 1'b1 || cfg_ack !== 1'b0 || phase_sel !== sel || phase_dir !== dir ||
            busy !== 1'b1 || phase_step_n !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ps_accept ack=%b cack=%b sel=%0d dir=%b busy=%b stepn=%b done=%b want 1 0 %0d %b 1 1 0",
                     ps_ack, cfg_ack, phase_sel, phase_dir, busy, phase_step_n, done, sel, dir);
        end
        total = 1 + steps * (PG + 1);
        for (int k = 1; k <= total; k++) begin
            ps_req = 1'($urandom);
            cfg_req = 1'($urandom);
            ps_sel_in = 3'($urandom);
            ps_dir_in = 1'($urandom);
            drive_cfg(rand_valid());
            tick();
            if (k == total) begin
                ps_req = 1'b0;
                cfg_req = 1'b0;
            end
            exp_low = ((k - 1) % (PG + 1) == 0) && ((k - 1) / (PG + 1) < steps);
            exp_done = (k == total);
            n_vec++;
            if (phase_step_n !== !exp_low || done !== exp_done || busy !== !exp_done ||
                phase_sel !== sel || phase_dir !== dir || ps_ack !== 1'b0 || cfg_ack !== 1'b0 ||
                err !== 1'b0 || dyn_obs !== exp_dyn) begin
                n_err++;
                $display("FAIL ps_seq steps=%0d k=%0d stepn=%b done=%b busy=%b sel=%0d dir=%b acks=%b%b err=%b want %b %b %b %0d %b 00 0",
                         steps, k, phase_step_n, done, busy, phase_sel, phase_dir, ps_ack, cfg_ack, err,
                         !exp_low, exp_done, !exp_done, sel, dir);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || phase_step_n !== 1'b1 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL ps_after done=%b stepn=%b lk=%b want 0 1 1", done, phase_step_n, locked);
        end
    endtask

    task automatic test_lock_loss();
        lock_en = 1'b0;
        tick();
        tick();
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL lockloss_early locked=%b want 1", locked);
        end
        tick();
        n_vec++;
        if (locked !== 1'b0 || busy !== 1'b0 || pll_rst_o !== 1'b0) begin
            n_err++;
            $display("FAIL lockloss_clear locked=%b busy=%b rst=%b want 0 0 0", locked, busy, pll_rst_o);
        end
        exp_locked = 0;
        ps_sel_in = 3'($urandom);
        ps_steps = 8'd1;
        ps_req = 1'b1;
        tick();
        ps_req = 1'b0;
        n_vec++;
        if (err !== 1'b1 || ps_ack !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ps_unlocked err=%b ack=%b busy=%b want 1 0 0", err, ps_ack, busy);
        end
        lock_en = 1'b1;
        repeat (5) tick();
        n_vec++;
        if (locked !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || phase_step_n !== 1'b1) begin
            n_err++;
            $display("FAIL lockloss_noauto locked=%b busy=%b err=%b stepn=%b want 0 0 0 1",
                     locked, busy, err, phase_step_n);
        end
    endtask

    task automatic test_reset_mid();
        int n, m;
        ps_sel_in = 3'd5;
        ps_dir_in = 1'b1;
        ps_steps = 8'd5;
        ps_req = 1'b1;
        tick();
        ps_req = 1'b0;
        tick();
        n_vec++;
        if (phase_step_n !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre stepn=%b busy=%b want 0 1", phase_step_n, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_dyn = INIT_PK;
        n_vec++;
        if (phase_step_n !== 1'b1 || dyn_obs !== INIT_PK || pll_rst_o !== 1'b1 || phase_sel !== 3'd0 ||
            busy !== 1'b1 || locked !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset stepn=%b dyn=%h rst=%b sel=%0d busy=%b lk=%b done=%b want 1 %h 1 0 1 0 0",
                     phase_step_n, dyn_obs, pll_rst_o, phase_sel, busy, locked, done, INIT_PK);
        end
        n = 0;
        while (pll_rst_o === 1'b1 && n < 4 * R) begin
            n++;
            tick();
        end
        m = 0;
        while (done !== 1'b1 && m < 4 * LS) begin
            if (phase_step_n !== 1'b1) n = -1;
            m++;
            tick();
        end
        n_vec++;
        if (n != R || m != LS + 2 || locked !== 1'b1 || dyn_obs !== INIT_PK) begin
            n_err++;
            $display("FAIL mid_relock hold=%0d lockwait=%0d lk=%b dyn=%h want %0d %0d 1 %h",
                     n, m, locked, dyn_obs, R, LS + 2, INIT_PK);
        end
        exp_locked = 1;
    endtask

    initial begin
        logic [5:0][9:0] v;
        exp_dyn = INIT_PK;
        exp_locked = 0;
        test_reset();

        v = {10'd20, 10'd10, 10'd20, 10'd10, 10'd40, 10'd2};
        test_cfg(v, 1'b0, 1'b1);
        test_cfg_invalid(8);

        test_phase(3'd2, 1'b1, 3);
        test_phase(3'd4, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            test_phase(3'($urandom), 1'($urandom), int'($urandom % 5));
        end

        // Simultaneous requests with duties at both legal extremes.
        v = rand_valid();
        v[2] = 10'(1 + $urandom % 500);
        v[4] = 10'(2 * int'(v[2]) - 1);
        v[5] = 10'd1;
        test_cfg(v, 1'b1, 1'b1);
        test_phase(3'($urandom), 1'($urandom), 2);

        test_lock_loss();

        lock_en = 1'b0;
        test_cfg(rand_valid(), 1'b0, 1'b0);
        lock_en = 1'b1;
        test_cfg(rand_valid(), 1'b0, 1'b1);
        test_phase(3'($urandom), 1'($urandom), 1);

        test_reset_mid();
        test_phase(3'($urandom), 1'($urandom), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
